mul_disp_ctrl: RTL and testbench

//  Sequencer between operand inputs, the 8x8 multiplier core (go/done/p) and the 4-digit 7-seg display.

---
 rtl/mul_disp_ctrl.sv | 147 ++++++++++++++
 tb/tb_mul_disp_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_disp_ctrl.sv
// Multiplier sequencer: launches the 8x8 core, converts its product to BCD by
// shift-add-3, and publishes the digits atomically to a free-running 4-digit scanner.
module mul_disp_ctrl #(
    parameter int SCAN_DIV = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  a_in,
    input  logic [7:0]  b_in,
    output logic        mul_go,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic        mul_done,
    input  logic [15:0] mul_p,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        ovf,
    output logic [19:0] bcd,
    output logic [3:0]  segen,
    output logic [3:0]  disp_bcd
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_CONVERT = 2'd3
    } state_t;

    // One shift-add-3 iteration on the {bcd[19:0], bin[15:0]} working register.
    function automatic logic [35:0] dd_step(input logic [35:0] w);
        logic [35:0] t;
        t = w;
        for (int i = 0; i < 5; i++) begin
            t[16+4*i +: 4] = (t[16+4*i +: 4] >= 4'd5) ? (t[16+4*i +: 4] + 4'd3)
                                                       : t[16+4*i +: 4];
        end
        return {t[34:0], 1'b0};
    endfunction

    state_t      state_r;
    logic [35:0] work_r;
    logic [3:0]  iter_r;
    logic [15:0] tcnt_r;
    logic [15:0] scan_cnt_r;
    logic [35:0] step_s;
    logic [35:0] first_s;

    // The capture edge already performs the first iteration, leaving 15 more in CONVERT.
    assign step_s  = dd_step(work_r);
    assign first_s = dd_step({20'd0, mul_p});

    // Sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            mul_go  <= 1'b0;
            mul_a   <= 8'd0;
            mul_b   <= 8'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            ovf     <= 1'b0;
            bcd     <= 20'd0;
            work_r  <= 36'd0;
            iter_r  <= 4'd0;
            tcnt_r  <= 16'd0;
        end else begin
            mul_go <= 1'b0;
            done   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mul_a   <= a_in;
                        mul_b   <= b_in;
                        err     <= 1'b0;
                        mul_go  <= 1'b1;
                        busy    <= 1'b1;
                        state_r <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    tcnt_r  <= 16'd0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mul_done) begin
                        work_r  <= first_s;
                        iter_r  <= 4'd1;
                        state_r <= ST_CONVERT;
                    end else if (tcnt_r >= 16'(TIMEOUT - 1)) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (tcnt_r != 16'hFFFF) begin
                        tcnt_r <= tcnt_r + 16'd1;
                    end
                end
                ST_CONVERT: begin
                    if (iter_r == 4'd15) begin
                        bcd     <= step_s[35:16];
                        ovf     <= |step_s[35:32];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        work_r <= step_s;
                        iter_r <= iter_r + 4'd1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Free-running digit scanner, independent of the sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_r <= 16'd0;
            segen      <= 4'b0001;
        end else if (scan_cnt_r >= 16'(SCAN_DIV - 1)) begin
            scan_cnt_r <= 16'd0;
            segen      <= {segen[2:0], segen[3]};
        end else begin
            scan_cnt_r <= scan_cnt_r + 16'd1;
        end
    end

    // Digit mux driven from the published digits only.
    always_comb begin
        disp_bcd = 4'd0;
        case (segen)
            4'b0001: disp_bcd = bcd[3:0];
            4'b0010: disp_bcd = bcd[7:4];
            4'b0100: disp_bcd = bcd[11:8];
            4'b1000: disp_bcd = bcd[15:12];
            default: disp_bcd = 4'd0;
        endcase
    end

endmodule

// File: tb/tb_mul_disp_ctrl.sv
// Self-checking bench for mul_disp_ctrl: the bench plays the multiplier and
// predicts digits, latency and scanner position from plain arithmetic.
module tb_mul_disp_ctrl;

    localparam int SCAN_DIV = 4;
    localparam int TIMEOUT  = 40;

    logic        clk = 1'b0;
    logic        rst, start, mul_done;
    logic [7:0]  a_in, b_in;
    logic [15:0] mul_p;
    logic        mul_go, busy, done, err, ovf;
    logic [7:0]  mul_a, mul_b;
    logic [19:0] bcd;
    logic [3:0]  segen, disp_bcd;

    int n_cmp = 0;
    int n_err = 0;
    int tick  = 0;
    logic [19:0] pub_bcd = 20'd0;
    logic        pub_ovf = 1'b0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int          d;
        bit          level;
        logic [19:0] exp_bcd;
        bit          exp_ovf;
    } vec_t;
    vec_t vecs[6];

    mul_disp_ctrl #(.SCAN_DIV(SCAN_DIV), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
        .mul_go(mul_go), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_p(mul_p),
        .busy(busy), .done(done), .err(err), .ovf(ovf), .bcd(bcd),
        .segen(segen), .disp_bcd(disp_bcd)
    );

    always #5 clk = ~clk;

    // Clocks since the last reset edge; locates the scanner position.
    always @(posedge clk) begin
        if (rst) tick <= 0;
        else     tick <= tick + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] to_bcd(input int p);
        int v;
        logic [19:0] r;
        v = p;
        r = 20'd0;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // One multiply; d = cycles after the go cycle before mul_done is raised.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int d,
                          input bit level, input bit inject, input bit stop_at_done);
        int go_cnt, done_cnt, done_k, hold_bad, p;
        p = int'(a) * int'(b);
        a_in = a; b_in = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("go_after_accept", mul_go, 1);
        check("busy_after_accept", busy, 1);
        check("err_cleared", err, 0);
        go_cnt = 0; done_cnt = 0; done_k = -1; hold_bad = 0;
        for (int k = 0; k <= d + 40; k++) begin
            if (k > 0) begin
                if (mul_go) go_cnt++;
                if (done) begin
                    done_cnt++;
                    if (done_k < 0) done_k = k;
                end
                if (mul_a !== a || mul_b !== b) hold_bad++;
                if (done_k >= 0 && (stop_at_done || k == done_k + 2)) break;
            end
            mul_done = level ? (k >= d && done_k < 0) : (k == d);
            mul_p    = mul_done ? 16'(p) : 16'($urandom);
            if (inject && k >= 1 && k <= d + 14) begin
                start = 1'($urandom);
                a_in  = 8'($urandom);
                b_in  = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        mul_done = 1'b0;
        start    = 1'b0;
        check("extra_go_pulses", go_cnt, 0);
        check("done_pulses", done_cnt, 1);
        check("done_latency", done_k, d + 16);
        check("operand_hold", hold_bad, 0);
        check("bcd_model", bcd, to_bcd(p));
        check("ovf_model", ovf, (p > 9999) ? 1 : 0);
        check("busy_end", busy, 0);
        pub_bcd = to_bcd(p);
        pub_ovf = (p > 9999);
    endtask

    task automatic check_scan(input int n);
        int idx;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            idx = (tick / SCAN_DIV) % 4;
            check("segen", segen, 4'b0001 << idx);
            check("disp_bcd", disp_bcd, pub_bcd[idx*4 +: 4]);
        end
    endtask

    initial begin
        int busy_k, done_seen;
        rst = 1'b1; start = 1'b0; mul_done = 1'b0; mul_p = 16'd0;
        a_in = 8'd0; b_in = 8'd0;
        vecs[0] = '{8'd12,  8'd11,  3, 1'b0, 20'h00132, 1'b0};
        vecs[1] = '{8'd255, 8'd255, 2, 1'b1, 20'h65025, 1'b1};
        vecs[2] = '{8'd0,   8'd200, 1, 1'b0, 20'h00000, 1'b0};
        vecs[3] = '{8'd100, 8'd100, 4, 1'b1, 20'h10000, 1'b1};
        vecs[4] = '{8'd99,  8'd101, 1, 1'b0, 20'h09999, 1'b0};
        vecs[5] = '{8'd100, 8'd101, 5, 1'b0, 20'h10100, 1'b1};
        repeat (3) @(posedge clk);
        #1;
        check("rst_go", mul_go, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_ovf", ovf, 0);
        check("rst_bcd", bcd, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_segen", segen, 4'b0001);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].level, 1'b0, 1'b0);
            check("vec_bcd", bcd, vecs[i].exp_bcd);
            check("vec_ovf", ovf, vecs[i].exp_ovf);
        end

        run_op(8'd255, 8'd255, 1, 1'b0, 1'b0, 1'b0);
        check_scan(4 * SCAN_DIV + 2);

        run_op(8'd77, 8'd201, 6, 1'b0, 1'b1, 1'b0);

        // Timeout: no mul_done ever; WAIT lasts TIMEOUT clocks.
        a_in = 8'd9; b_in = 8'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy_k = -1;
        for (int k = 1; k <= TIMEOUT + 10; k++) begin
            @(posedge clk); #1;
            if (!busy && busy_k < 0) busy_k = k;
        end
        check("timeout_len", busy_k, TIMEOUT + 1);
        check("timeout_err", err, 1);
        check("timeout_bcd_kept", bcd, pub_bcd);
        check("timeout_ovf_kept", ovf, pub_ovf);
        run_op(8'd3, 8'd7, 2, 1'b0, 1'b0, 1'b0);
        check("err_after_good", err, 0);

        // Start in the done cycle is accepted.
        run_op(8'd10, 8'd10, 2, 1'b0, 1'b0, 1'b1);
        run_op(8'd50, 8'd60, 1, 1'b1, 1'b0, 1'b0);

        // Reset mid-CONVERT.
        a_in = 8'd37; b_in = 8'd91; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            mul_done = (k == 2);
            mul_p    = 16'(37 * 91);
            @(posedge clk); #1;
        end
        mul_done = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_bcd", bcd, 0);
        check("midrst_ovf", ovf, 0);
        check("midrst_segen", segen, 4'b0001);
        check("midrst_done", done, 0);
        pub_bcd = 20'd0; pub_ovf = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);
        run_op(8'd37, 8'd91, 3, 1'b0, 1'b0, 1'b0);
        check_scan(SCAN_DIV * 2);

        for (int i = 0; i < 25; i++) begin
            run_op(8'($urandom), 8'($urandom), $urandom_range(1, 6),
                   1'($urandom), 1'($urandom), 1'b0);
        end
        check_scan(SCAN_DIV * 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
